// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (ADD/MUL/LDR/STR/MOV/DPRO) with valid/ready handshake and a dot-product accumulator.
// Define ALU_SAT_EN to saturate overflowing results instead of wrapping them.
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op_code,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3'b000);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(3'b001);
  localparam logic [OP_W-1:0] OP_LDR  = OP_W'(3'b100);
  localparam logic [OP_W-1:0] OP_STR  = OP_W'(3'b101);
  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(3'b110);
  localparam logic [OP_W-1:0] OP_DPRO = OP_W'(3'b111);

  typedef enum logic {IDLE, ACCUM} dpro_state_e;

  logic                     s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]          s1_op_q, s1_op_d;
  logic signed [DATA_W-1:0] s1_a_q, s1_a_d;
  logic signed [DATA_W-1:0] s1_b_q, s1_b_d;
  logic                     s1_last_q, s1_last_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  dpro_state_e              state_q, state_d;

  logic                     adv, in_fire;
  logic signed [DATA_W:0]   sum;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum_ext, prod_ext, dpro_sum;
  logic [ACC_W-1:0]         res_wide;
  logic [ACC_W-DATA_W:0]    res_hi;
  logic [DATA_W-1:0]        res_data;
  logic                     res_ovf, res_chk, res_emit;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // All candidate results are widened to ACC_W so one range check covers ADD, MUL and DPRO.
  assign sum      = (DATA_W+1)'(s1_a_q) + (DATA_W+1)'(s1_b_q);
  assign prod     = (2*DATA_W)'(s1_a_q) * (2*DATA_W)'(s1_b_q);
  assign sum_ext  = ACC_W'(sum);
  assign prod_ext = ACC_W'(prod);
  assign dpro_sum = $signed(acc_q) + prod_ext;

  always_comb begin
    res_wide = '0;
    res_chk  = 1'b0;
    res_emit = 1'b1;
    res_data = '0;
    res_ovf  = 1'b0;
    res_hi   = '0;
    case (s1_op_q)
      OP_ADD, OP_LDR, OP_STR: begin
        res_wide = sum_ext;
        res_chk  = 1'b1;
      end
      OP_MUL: begin
        res_wide = prod_ext;
        res_chk  = 1'b1;
      end
      OP_MOV: res_data = s1_a_q;
      OP_DPRO: begin
        if (s1_last_q) begin
          res_wide = dpro_sum;
          res_chk  = 1'b1;
        end else begin
          res_emit = 1'b0;
        end
      end
      default: ;
    endcase
    // In range only when every bit from DATA_W-1 upward is a copy of the sign.
    if (res_chk) begin
      res_hi   = res_wide[ACC_W-1:DATA_W-1];
      res_ovf  = !((&res_hi) || !(|res_hi));
      res_data = res_wide[DATA_W-1:0];
`ifdef ALU_SAT_EN
      if (res_ovf)
        res_data = res_wide[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    state_d     = state_q;
    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;
    // Non-final DPRO elements retire into the accumulator without occupying stage 2.
    if (s1_valid_q && adv) begin
      s1_valid_d = 1'b0;
      if (res_emit) begin
        out_valid_d = 1'b1;
        out_data_d  = res_data;
        out_ovf_d   = res_ovf;
      end
      if (s1_op_q == OP_DPRO) begin
        if (s1_last_q) begin
          acc_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d   = dpro_sum;
          state_d = ACCUM;
        end
      end
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op_code;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_last_d  = in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      state_q     <= IDLE;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the combinational datapath ALU.
- Same op set: ADD, MUL, LDR, STR, MOV, DPRO.
- Adds valid/ready handshaking, a 2-stage pipeline, overflow flagging, and a true multi-element dot-product accumulator.
- Sits between the instruction decode/operand fetch stage and writeback; LDR/STR use it for address generation.

Parameters:
DATA_W, 32, operand and result width (signed, two's complement); minimum 8
ACC_W, 64, dot-product accumulator width; must be >= 2*DATA_W
OP_W, 3, op code width; encodings are ADD=000, MUL=001, LDR=100, STR=101, MOV=110, DPRO=111

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready
op_code  in  OP_W  operation select
in_a  in  DATA_W  signed operand A
in_b  in  DATA_W  signed operand B
in_last  in  1  DPRO only: final element of the dot-product burst; ignored for other ops
out_valid  out  1  result available
out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready
out_data  out  DATA_W  signed result
out_ovf  out  1  result did not fit DATA_W signed (qualified by out_valid)

Behaviour:
- Reset (async assert, sync release):
  - s1_valid, out_valid, out_data and out_ovf are 0.
  - Accumulator is 0; DPRO state is IDLE.
  - in_ready is 1 once out of reset.
  - Any partial DPRO burst is discarded.
- Stage 1 registers op_code, in_a, in_b and in_last on input transfer.
- Stage 2 computes and loads out_data/out_ovf/out_valid.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = !s1_valid || adv, combinational.
  - Stage 1 moves to stage 2 when s1_valid && adv.
- Latency and throughput:
  - out_valid rises 2 cycles after input transfer when not stalled.
  - Throughput is 1 op/cycle.
  - Order is strictly preserved.
- While out_valid && !out_ready, out_data/out_ovf are held stable.
- ADD/LDR/STR:
  - sum = in_a + in_b computed at DATA_W+1 bits.
  - out_data = sum[DATA_W-1:0].
  - out_ovf = sum[DATA_W] != sum[DATA_W-1].
- MUL:
  - prod = in_a * in_b computed at 2*DATA_W bits.
  - out_data = low DATA_W bits.
  - out_ovf = 1 if prod is outside the signed DATA_W range.
- MOV: out_data = in_a, out_ovf = 0.
- Undefined op codes (010, 011): out_data = 0, out_ovf = 0; the result is still emitted.
- DPRO state machine (IDLE, ACCUM):
  - Element with in_last=0: acc <= acc + prod, computed mod 2^ACC_W. No output is produced and the stage-2 slot is not occupied. State goes to ACCUM.
  - Element with in_last=1: result = acc + prod. out_data = low DATA_W bits; out_ovf = result outside signed DATA_W range. acc <= 0; state goes to IDLE.
  - A single DPRO with in_last=1 from IDLE equals MUL.
  - Non-DPRO ops arriving in ACCUM execute normally, emit their result, and leave acc/state untouched (interleave allowed).
  - ACC_W overflow wraps silently; it is not flagged.
- Simultaneous events:
  - An output transfer and a new stage-2 load in the same cycle is allowed; the new result replaces the old one, with out_valid staying 1.
  - An accumulating DPRO element advances whenever adv holds, independent of out_ready only via adv.
- Reset mid-operation: all in-flight ops and the accumulator are lost; no output is emitted for them.

Optional Feature:
- ALU_SAT_EN defined:
  - When the overflow condition holds, out_data saturates to the signed maximum (2^(DATA_W-1)-1) or minimum (-2^(DATA_W-1)), following the sign of the full-width result.
  - out_ovf is still asserted.
  - Applies to ADD/LDR/STR, MUL and DPRO final results.
- ALU_SAT_EN undefined: two's-complement wrap (truncation) as above.

Test Plan:
- ADD in_a=5, in_b=-3, out_ready=1 -> out_valid 2 cycles after accept; out_data=2, out_ovf=0.
- ADD 0x7FFFFFFF + 1 -> out_data=0x80000000, out_ovf=1. With ALU_SAT_EN: out_data=0x7FFFFFFF, out_ovf=1.
- MUL -4 * 6 -> out_data=0xFFFFFFE8. MUL 0x10000 * 0x10000 -> out_data=0, out_ovf=1.
- DPRO (1,2,last=0), (3,4,last=0), (5,6,last=1) -> exactly one output, out_data=44. Interleave an ADD 1+1 after the second element -> output 2 appears first, then 44.
- Stream 4 ops with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, out_data held stable, no loss. Release out_ready -> all 4 results in order, one per cycle.
- Assert rst_n low after 2 DPRO elements, release, send DPRO (2,3,last=1) -> out_data=6. Also check outputs are 0 during reset.
